// File: rtl/fsmd_arith_unit.sv
// rtl/fsmd_arith_unit.sv - multi-cycle add/sub/shift-add multiply FSMD with valid/ready channels
module fsmd_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDSUB = 2'd1,
        MUL    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] b_shift;
    logic [2*WIDTH-1:0] addsub_res;
    logic               addsub_err;
    logic [CW-1:0]      cnt;
    logic               a_bit;
    logic               mul_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (op == 2'b10) ? MUL : ADDSUB;
                end
            end
            ADDSUB: state_next = DONE;
            MUL: begin
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // One multiplier bit per cycle: the partial product b << i is added when a[i] is set.
    always_comb begin
        mul_last = (cnt == CW'(WIDTH - 1));
        a_bit    = |(a_reg & (WIDTH'(1) << cnt));
        b_shift  = {{WIDTH{1'b0}}, b_reg} << cnt;
        acc_next = acc + (a_bit ? b_shift : '0);
    end

    always_comb begin
        addsub_res = '0;
        addsub_err = 1'b0;
        case (op_reg)
            2'b00:   addsub_res = {{(WIDTH-1){1'b0}}, {1'b0, a_reg} + {1'b0, b_reg}};
            2'b01:   addsub_res = {{(WIDTH-1){1'b0}}, {1'b0, a_reg} - {1'b0, b_reg}};
            2'b11:   addsub_err = 1'b1;
            default: addsub_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_reg <= op;
                        a_reg  <= a;
                        b_reg  <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ADDSUB: begin
                    result <= addsub_res;
                    err    <= addsub_err;
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (mul_last) begin
                        result <= acc_next;
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsmd_arith_unit.sv
// tb/tb_fsmd_arith_unit.sv - directed self-checking bench for fsmd_arith_unit (WIDTH=8)
module tb_fsmd_arith_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fsmd_arith_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_result"}, result, 16'h0000);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    // Issues one command in an IDLE cycle and follows it to hand-off.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input int lat, input logic [15:0] exp_r,
                         input logic exp_e, input int hold);
        out_ready = (hold == 0);
        op        = o;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        chk({tag, "_accept_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        a        = ~x;
        b        = ~y;
        op       = ~o;
        for (int i = 1; i < lat; i++) begin
            chk({tag, "_early_valid"}, out_valid, 1'b0);
            chk({tag, "_busy"}, busy, 1'b1);
            tick();
        end
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_err"}, err, exp_e);
        chk({tag, "_in_ready_done"}, in_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 2 == 0);
            a        = 8'($urandom);
            b        = 8'($urandom);
            op       = 2'($urandom);
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_result"}, result, exp_r);
            chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        if (hold > 0) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
        end else begin
            tick();
        end
        chk({tag, "_pulse_end"}, out_valid, 1'b0);
        chk({tag, "_idle_ready"}, in_ready, 1'b1);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_held_result"}, result, exp_r);
        chk({tag, "_held_err"}, err, exp_e);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 2'b00;
        a         = 8'd0;
        b         = 8'd0;
        out_ready = 1'b1;
        tick();
        tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();

        do_op("add_200_100", 2'b00, 8'd200, 8'd100, 2, 16'h012C, 1'b0, 0);
        do_op("sub_5_7", 2'b01, 8'd5, 8'd7, 2, 16'h01FE, 1'b0, 0);
        do_op("sub_7_5", 2'b01, 8'd7, 8'd5, 2, 16'h0002, 1'b0, 0);
        do_op("mul_255_255", 2'b10, 8'd255, 8'd255, 9, 16'hFE01, 1'b0, 0);
        do_op("mul_0_200", 2'b10, 8'd0, 8'd200, 9, 16'h0000, 1'b0, 0);
        do_op("mul_1_1", 2'b10, 8'd1, 8'd1, 9, 16'h0001, 1'b0, 0);
        do_op("illegal", 2'b11, 8'd3, 8'd4, 2, 16'h0000, 1'b1, 0);
        do_op("add_1_1", 2'b00, 8'd1, 8'd1, 2, 16'h0002, 1'b0, 0);
        do_op("bp_add", 2'b00, 8'd10, 8'd20, 2, 16'h001E, 1'b0, 5);

        // Consume and offer a new command in the same DONE cycle.
        out_ready = 1'b0;
        op        = 2'b00;
        a         = 8'd3;
        b         = 8'd4;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("sim_done_valid", out_valid, 1'b1);
        chk("sim_done_result", result, 16'h0007);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'd1;
        b         = 8'd2;
        tick();
        chk("sim_not_accepted", in_ready, 1'b1);
        chk("sim_valid_drop", out_valid, 1'b0);
        chk("sim_result_held", result, 16'h0007);
        tick();
        in_valid = 1'b0;
        chk("sim_later_accept", busy, 1'b1);
        tick();
        chk("sim_second_valid", out_valid, 1'b1);
        chk("sim_second_result", result, 16'h0003);
        tick();
        chk("sim_back_idle", in_ready, 1'b1);

        // Abort a multiply in its 4th compute cycle.
        op       = 2'b10;
        a        = 8'd13;
        b        = 8'd11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("abort");
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_valid", out_valid, 1'b0);
        end
        do_op("mul_13_11", 2'b10, 8'd13, 8'd11, 9, 16'h008F, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
